ntt_stage_scheduler: RTL

Start/done sequencer for the radix-R single-path NTT pipeline. One transform is accepted on a `start` pulse. The block then streams N/R sample groups into stage 0 and opens a staggered enable window on each butterfly stage. It also produces the per-stage twiddle base exponents that the twiddle ROM address logic multiplies by the lane index. It sits between the top-level RLWE control and the butterfly/commutator stage chain.

---
 rtl/ntt_stage_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ntt_stage_scheduler.sv
// Start/done sequencer for the radix-R single-path NTT pipeline: master count, staggered stage enables, twiddle base exponents.
// Optional inverse-exponent mode is compiled in with the NTT_SCHED_INVERSE_EN macro.
module ntt_stage_scheduler #(
  parameter int N         = 256,
  parameter int R         = 4,
  parameter int L         = 4,
  parameter int STAGE_LAT = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stall,
`ifdef NTT_SCHED_INVERSE_EN
  input  logic                          inverse,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          in_ready,
  output logic [L-1:0]                  stage_en,
  output logic [(L-1)*$clog2(N)-1:0]    tw_base
);

  localparam int LOGN  = $clog2(N);
  localparam int LOGR  = $clog2(R);
  localparam int NG    = N / R;
  localparam int T_END = (L - 1) * STAGE_LAT + NG;
  localparam int TW    = $clog2(T_END + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [TW-1:0]   t_q;
  logic            busy_q;
  logic            done_q;
  logic            accept;
  logic            run_act;
  logic            inv_sel;

  assign accept  = (state_q == IDLE) && start;
  assign run_act = (state_q == RUN) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            t_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!stall) begin
            t_q <= t_q + TW'(1);
            if (t_q == TW'(T_END - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = run_act && (t_q < TW'(NG));

`ifdef NTT_SCHED_INVERSE_EN
  logic inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      inv_q <= 1'b0;
    else if (accept) inv_q <= inverse;
  end

  assign inv_sel = inv_q;
`else
  assign inv_sel = 1'b0;
`endif

  // Stage s owns the NG-cycle window starting at s*STAGE_LAT on the master count.
  for (genvar s = 0; s < L; s++) begin : g_en
    localparam logic [TW-1:0] HI = TW'(s * STAGE_LAT + NG);
    if (s == 0) begin : g_first
      assign stage_en[s] = run_act && (t_q < HI);
    end else begin : g_rest
      localparam logic [TW-1:0] LO = TW'(s * STAGE_LAT);
      assign stage_en[s] = run_act && (t_q >= LO) && (t_q < HI);
    end
  end

  // Counter width makes the wrap modulo N/R^(s+1) free; shifting by s*log2(R) scales by R^s.
  for (genvar s = 0; s < L - 1; s++) begin : g_tw
    localparam int CW = LOGN - LOGR * (s + 1);
    logic [CW-1:0]   c_q;
    logic [CW-1:0]   c_d;
    logic [LOGN-1:0] e_fwd;

    always_comb begin
      c_d = c_q;
      if (accept)           c_d = '0;
      else if (stage_en[s]) c_d = c_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) c_q <= '0;
      else        c_q <= c_d;
    end

    assign e_fwd = LOGN'(c_q) << (LOGR * s);
    assign tw_base[s*LOGN +: LOGN] = inv_sel ? (~e_fwd + LOGN'(1)) : e_fwd;
  end

endmodule
